// File: rtl/game_fsm_pkg.sv
// game_pkg: shared state/direction encodings, default parameters and
// the state-to-strobe decode used by the snake game controller.
package game_pkg;

  localparam int DEF_SCORE_W     = 8;
  localparam int DEF_LIVES       = 3;
  localparam int DEF_BASE_PERIOD = 16;
  localparam int DEF_MIN_PERIOD  = 4;
  localparam int DEF_STEP_PERIOD = 2;
  localparam int DEF_LEVEL_SHIFT = 2;
  localparam int DEF_MAX_LEVEL   = 7;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START   = 4'd1,
    S_GENFOOD = 4'd2,
    S_RENDER  = 4'd3,
    S_WAIT    = 4'd4,
    S_MOVE    = 4'd5,
    S_CHECK   = 4'd6,
    S_PAUSE   = 4'd7,
    S_DEAD    = 4'd8,
    S_OVER    = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef struct packed {
    logic clear;
    logic snake_rst;
    logic gen_food;
    logic flash;
    logic move_en;
    logic game_over;
  } strobe_t;

  // Moore decode: every strobe is a pure function of the state it belongs to.
  function automatic strobe_t stb_of(state_e s);
    strobe_t t;
    t           = '0;
    t.clear     = (s == S_IDLE);
    t.snake_rst = (s == S_START);
    t.gen_food  = (s == S_GENFOOD);
    t.flash     = (s == S_RENDER);
    t.move_en   = (s == S_MOVE);
    t.game_over = (s == S_OVER);
    return t;
  endfunction

  // Same axis (bit1) but opposite sense (bit0) means a 180-degree turn.
  function automatic logic is_reverse(logic [1:0] req, logic [1:0] cur);
    return (req[1] == cur[1]) && (req[0] != cur[0]);
  endfunction

endpackage

// File: rtl/game_fsm_if.sv
// game_fsm_if: handshake and status bundle between the game controller
// (slave side) and the food generator / renderer / input logic (master side).
interface game_fsm_if import game_pkg::*; #(
  parameter int SCORE_W   = DEF_SCORE_W,
  parameter int LIVES     = DEF_LIVES,
  parameter int MAX_LEVEL = DEF_MAX_LEVEL
);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);

  logic               start;
  logic               pause;
  logic               gen_done;
  logic               render_done;
  logic               collide;
  logic [1:0]         dir_in;
  logic [SCORE_W-1:0] score;

  logic               clear;
  logic               snake_rst;
  logic               gen_food;
  logic               flash;
  logic               move_en;
  logic               game_over;
  logic [1:0]         dir_out;
  logic [SCORE_W-1:0] score_out;
  logic [LIVES_W-1:0] lives;
  logic [LEVEL_W-1:0] level;
  logic [3:0]         state;

  modport master (
    output start, pause, gen_done, render_done, collide, dir_in, score,
    input  clear, snake_rst, gen_food, flash, move_en, game_over,
           dir_out, score_out, lives, level, state
  );

  modport slave (
    input  start, pause, gen_done, render_done, collide, dir_in, score,
    output clear, snake_rst, gen_food, flash, move_en, game_over,
           dir_out, score_out, lives, level, state
  );

endinterface

// File: rtl/game_fsm_move_timer.sv
// move_timer: level-dependent move period and saturating tick counter.
// The clearing cycle (MOVE) counts as the first cycle of the next period,
// so move_en pulses are spaced exactly one period apart.
module move_timer import game_pkg::*; #(
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int STEP_PERIOD = DEF_STEP_PERIOD,
  parameter int LEVEL_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] i_level,
  input  logic               i_run,
  input  logic               i_clr,
  output logic               o_tick
);
  localparam int CNT_W = $clog2(BASE_PERIOD);
  localparam int SPAN  = BASE_PERIOD - MIN_PERIOD;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BASE_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_red;
  logic [31:0]      w_period;

  // Period shrinks with level; clamp before subtracting so it never underflows.
  always_comb begin
    w_red    = 32'(i_level) * 32'(STEP_PERIOD);
    w_period = (w_red >= 32'(SPAN)) ? 32'(MIN_PERIOD) : 32'(BASE_PERIOD) - w_red;
  end

  assign o_tick = (32'(r_cnt) >= (w_period - 32'd1));

  // Counter saturates at the longest threshold, so it can never wrap back below it.
  always_ff @(posedge clk) begin
    if (rst)                             r_cnt <= '0;
    else if (i_clr)                      r_cnt <= i_run ? CNT_W'(1) : '0;
    else if (i_run && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/game_fsm.sv
// game_fsm: snake game sequencer. Registered Moore strobes, lives/score
// bookkeeping, direction filtering and a level-scaled move timer.
module game_fsm import game_pkg::*; #(
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int LIVES       = DEF_LIVES,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int STEP_PERIOD = DEF_STEP_PERIOD,
  parameter int LEVEL_SHIFT = DEF_LEVEL_SHIFT,
  parameter int MAX_LEVEL   = DEF_MAX_LEVEL
) (
  input  logic       clk,
  input  logic       rst,
  game_fsm_if.slave  bus
);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);

  state_e             r_state, w_nxt_state;
  strobe_t            r_stb, w_nxt_stb;
  logic [LIVES_W-1:0] r_lives, w_nxt_lives;
  logic [SCORE_W-1:0] r_score_q, w_nxt_score_q;
  logic [1:0]         r_dir, w_nxt_dir;
  logic [SCORE_W-1:0] w_lvl_raw;
  logic [LEVEL_W-1:0] w_level;
  logic               w_tick, w_run, w_clr;

  // Level follows the live score combinationally, saturating at MAX_LEVEL.
  always_comb begin
    w_lvl_raw = bus.score >> LEVEL_SHIFT;
    w_level   = (32'(w_lvl_raw) > 32'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL)
                                                  : LEVEL_W'(w_lvl_raw);
  end

  // Timer runs through the play loop, freezes in PAUSE/DEAD/OVER, restarts on MOVE.
  assign w_run = r_state inside {S_START, S_GENFOOD, S_RENDER, S_WAIT, S_CHECK, S_MOVE};
  assign w_clr = r_state inside {S_IDLE, S_MOVE};

  move_timer #(
    .BASE_PERIOD (BASE_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD),
    .STEP_PERIOD (STEP_PERIOD),
    .LEVEL_W     (LEVEL_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_level (w_level),
    .i_run   (w_run),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

  // Next-state, bookkeeping and strobe decode; handshakes only matter in their own state.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_lives   = r_lives;
    w_nxt_score_q = r_score_q;
    w_nxt_dir     = r_dir;
    unique case (r_state)
      S_IDLE: if (bus.start) begin
        w_nxt_state   = S_START;
        w_nxt_lives   = LIVES_W'(LIVES);
        w_nxt_score_q = '0;
        w_nxt_dir     = DIR_UP;
      end
      S_START:   w_nxt_state = S_GENFOOD;
      S_GENFOOD: if (bus.gen_done)    w_nxt_state = S_RENDER;
      S_RENDER:  if (bus.render_done) w_nxt_state = S_WAIT;
      S_WAIT: begin
        if (bus.pause)   w_nxt_state = S_PAUSE;
        else if (w_tick) w_nxt_state = S_MOVE;
      end
      S_PAUSE:   if (!bus.pause) w_nxt_state = S_WAIT;
      S_MOVE: begin
        w_nxt_state = S_CHECK;
        if (!is_reverse(bus.dir_in, r_dir)) w_nxt_dir = bus.dir_in;
      end
      S_CHECK: begin
        w_nxt_score_q = bus.score;
        if (bus.collide)                w_nxt_state = S_DEAD;
        else if (bus.score != r_score_q) w_nxt_state = S_GENFOOD;
        else                            w_nxt_state = S_RENDER;
      end
      S_DEAD: begin
        w_nxt_lives = (r_lives != '0) ? r_lives - LIVES_W'(1) : '0;
        w_nxt_state = (r_lives <= LIVES_W'(1)) ? S_OVER : S_START;
      end
      S_OVER:    if (bus.start) w_nxt_state = S_IDLE;
      default:   w_nxt_state = S_IDLE;
    endcase
    w_nxt_stb = stb_of(w_nxt_state);
  end

  // State and all strobes registered together; reset lands directly in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_stb     <= stb_of(S_IDLE);
      r_lives   <= '0;
      r_score_q <= '0;
      r_dir     <= DIR_UP;
    end else begin
      r_state   <= w_nxt_state;
      r_stb     <= w_nxt_stb;
      r_lives   <= w_nxt_lives;
      r_score_q <= w_nxt_score_q;
      r_dir     <= w_nxt_dir;
    end
  end

  assign bus.clear     = r_stb.clear;
  assign bus.snake_rst = r_stb.snake_rst;
  assign bus.gen_food  = r_stb.gen_food;
  assign bus.flash     = r_stb.flash;
  assign bus.move_en   = r_stb.move_en;
  assign bus.game_over = r_stb.game_over;
  assign bus.dir_out   = r_dir;
  assign bus.score_out = bus.score;
  assign bus.lives     = r_lives;
  assign bus.level     = w_level;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: directed vector table for the play loop plus hand sequences
// for move spacing, pause, game over and mid-game reset.
module tb_game_fsm;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_fsm_if #(.SCORE_W(8), .LIVES(3), .MAX_LEVEL(7)) bus();

  game_fsm #(
    .SCORE_W(8), .LIVES(3), .BASE_PERIOD(16), .MIN_PERIOD(4),
    .STEP_PERIOD(2), .LEVEL_SHIFT(2), .MAX_LEVEL(7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic       s, p, g, r, c;
    logic [1:0] d;
    logic [7:0] sc;
    state_e     st;
    logic [1:0] dout;
    logic [1:0] lv;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic s, logic p, logic g, logic r, logic c,
                              logic [1:0] d, logic [7:0] sc,
                              state_e st, logic [1:0] dout, logic [1:0] lv);
    vec_t v;
    v.s = s; v.p = p; v.g = g; v.r = r; v.c = c; v.d = d; v.sc = sc;
    v.st = st; v.dout = dout; v.lv = lv;
    return v;
  endfunction

  // {clear, snake_rst, gen_food, flash, move_en, game_over}
  function automatic int exp_stb(state_e s);
    case (s)
      S_IDLE:    return 6'b100000;
      S_START:   return 6'b010000;
      S_GENFOOD: return 6'b001000;
      S_RENDER:  return 6'b000100;
      S_MOVE:    return 6'b000010;
      S_OVER:    return 6'b000001;
      default:   return 6'b000000;
    endcase
  endfunction

  function automatic int act_stb();
    return int'({bus.clear, bus.snake_rst, bus.gen_food, bus.flash, bus.move_en, bus.game_over});
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.start = v.s; bus.pause = v.p; bus.gen_done = v.g; bus.render_done = v.r;
    bus.collide = v.c; bus.dir_in = v.d; bus.score = v.sc;
  endtask

  task automatic wait_move(output int cyc);
    cyc = -1;
    for (int k = 0; k < 200; k++) begin
      step();
      if (bus.move_en) begin
        cyc = k + 1;
        break;
      end
    end
  endtask

  task automatic wait_state(input state_e tgt, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (int'(bus.state) == int'(tgt)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic measure(input logic [7:0] sc, input int exp, input string nm);
    int c;
    bus.score = sc;
    wait_move(c);
    wait_move(c);
    wait_move(c);
    chk(nm, c, exp);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " state"}, int'(bus.state), int'(S_IDLE));
    chk({nm, " strobes"}, act_stb(), 6'b100000);
    chk({nm, " lives"}, int'(bus.lives), 0);
    chk({nm, " dir"}, int'(bus.dir_out), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  c, bad;
    bit  ok;
    int  lv_sc[8] = '{0, 3, 4, 12, 28, 31, 100, 255};
    int  lv_ex[8] = '{0, 0, 1, 3, 7, 7, 7, 7};

    bus.start = 0; bus.pause = 0; bus.gen_done = 0; bus.render_done = 0;
    bus.collide = 0; bus.dir_in = 2'b00; bus.score = 8'd0;

    // reset state
    rst = 1'b1;
    step(); step();
    chk_idle("reset");
    rst = 1'b0;
    step();
    chk_idle("post-reset");

    // vector table: start-up handshake, WAIT period, direction filter, death
    vq.push_back(mk(1,0,0,0,0,2'b00,8'd0, S_START,   2'b00, 2'd3));
    vq.push_back(mk(0,0,0,1,1,2'b00,8'd0, S_GENFOOD, 2'b00, 2'd3));
    vq.push_back(mk(1,0,0,1,0,2'b00,8'd0, S_GENFOOD, 2'b00, 2'd3));
    vq.push_back(mk(0,0,0,0,1,2'b00,8'd0, S_GENFOOD, 2'b00, 2'd3));
    vq.push_back(mk(0,0,1,0,0,2'b00,8'd0, S_RENDER,  2'b00, 2'd3));
    vq.push_back(mk(0,0,1,0,1,2'b00,8'd0, S_RENDER,  2'b00, 2'd3));
    vq.push_back(mk(0,0,0,1,0,2'b00,8'd0, S_WAIT,    2'b00, 2'd3));
    for (int i = 0; i < 9; i++)
      vq.push_back(mk(1,0,1,1,1,2'b00,8'd0, S_WAIT,  2'b00, 2'd3));
    vq.push_back(mk(0,0,0,0,0,2'b00,8'd0, S_MOVE,    2'b00, 2'd3));
    vq.push_back(mk(0,0,0,0,1,2'b11,8'd0, S_CHECK,   2'b11, 2'd3));
    vq.push_back(mk(0,0,0,0,0,2'b00,8'd0, S_RENDER,  2'b11, 2'd3));
    vq.push_back(mk(0,0,0,1,0,2'b00,8'd0, S_WAIT,    2'b11, 2'd3));
    for (int i = 0; i < 12; i++)
      vq.push_back(mk(0,0,0,0,0,2'b01,8'd0, S_WAIT,  2'b11, 2'd3));
    vq.push_back(mk(0,0,0,0,0,2'b00,8'd0, S_MOVE,    2'b11, 2'd3));
    vq.push_back(mk(0,0,0,0,0,2'b10,8'd0, S_CHECK,   2'b11, 2'd3));
    vq.push_back(mk(0,0,0,0,0,2'b00,8'd5, S_GENFOOD, 2'b11, 2'd3));
    vq.push_back(mk(0,0,1,0,0,2'b00,8'd5, S_RENDER,  2'b11, 2'd3));
    vq.push_back(mk(0,0,0,1,0,2'b00,8'd5, S_WAIT,    2'b11, 2'd3));
    for (int i = 0; i < 9; i++)
      vq.push_back(mk(0,0,0,0,0,2'b00,8'd5, S_WAIT,  2'b11, 2'd3));
    vq.push_back(mk(0,0,0,0,0,2'b00,8'd5, S_MOVE,    2'b11, 2'd3));
    vq.push_back(mk(0,0,0,0,0,2'b00,8'd5, S_CHECK,   2'b00, 2'd3));
    vq.push_back(mk(0,0,0,0,1,2'b00,8'd5, S_DEAD,    2'b00, 2'd3));
    vq.push_back(mk(0,0,0,0,0,2'b00,8'd5, S_START,   2'b00, 2'd2));
    vq.push_back(mk(0,0,0,0,0,2'b00,8'd5, S_GENFOOD, 2'b00, 2'd2));

    foreach (vq[i]) begin
      drive(vq[i]);
      step();
      chk($sformatf("v%0d state", i),   int'(bus.state),     int'(vq[i].st));
      chk($sformatf("v%0d strobes", i), act_stb(),           exp_stb(vq[i].st));
      chk($sformatf("v%0d dir", i),     int'(bus.dir_out),   int'(vq[i].dout));
      chk($sformatf("v%0d lives", i),   int'(bus.lives),     int'(vq[i].lv));
      chk($sformatf("v%0d score_out", i), int'(bus.score_out), int'(vq[i].sc));
    end

    // level = min(score >> 2, 7)
    for (int k = 0; k < 8; k++) begin
      bus.score = 8'(lv_sc[k]);
      #1;
      chk($sformatf("level score=%0d", lv_sc[k]), int'(bus.level), lv_ex[k]);
    end

    // move spacing at level 0, then pause at count 7
    bus.gen_done = 1; bus.render_done = 1; bus.collide = 0; bus.pause = 0;
    measure(8'd0, 16, "period level0");
    for (int k = 0; k < 7; k++) step();
    chk("pre-pause state", int'(bus.state), int'(S_WAIT));
    bus.pause = 1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (bus.move_en) bad++;
    end
    chk("pause move_en count", bad, 0);
    chk("pause state", int'(bus.state), int'(S_PAUSE));
    chk("pause strobes", act_stb(), 0);
    bus.pause = 0;
    wait_move(c);
    chk("pause release delay", c, 9);

    measure(8'd12,  10, "period level3");
    measure(8'd255,  4, "period level7");

    // three deaths -> game over -> idle
    rst = 1; step(); rst = 0;
    bus.score = 8'd0; bus.dir_in = 2'b00;
    bus.start = 1; step(); bus.start = 0;
    chk("restart lives", int'(bus.lives), 3);
    chk("restart state", int'(bus.state), int'(S_START));
    bus.collide = 1;
    for (int i = 1; i <= 3; i++) begin
      wait_state(S_DEAD, ok);
      chk($sformatf("death%0d reached", i), int'(ok), 1);
      chk($sformatf("death%0d lives in DEAD", i), int'(bus.lives), 4 - i);
      step();
      chk($sformatf("death%0d lives after", i), int'(bus.lives), 3 - i);
      chk($sformatf("death%0d next state", i), int'(bus.state),
          (i < 3) ? int'(S_START) : int'(S_OVER));
    end
    chk("over strobes", act_stb(), 6'b000001);
    step(); step(); step();
    chk("over holds", int'(bus.state), int'(S_OVER));
    bus.start = 1; step(); bus.start = 0;
    chk("over->idle state", int'(bus.state), int'(S_IDLE));
    chk("over->idle strobes", act_stb(), 6'b100000);

    // reset mid-game in RENDER with two lives left
    bus.collide = 1; bus.dir_in = 2'b11;
    bus.start = 1; step(); bus.start = 0;
    wait_state(S_DEAD, ok);
    chk("midreset death reached", int'(ok), 1);
    bus.collide = 0; bus.render_done = 0;
    step();
    wait_state(S_RENDER, ok);
    chk("midreset render reached", int'(ok), 1);
    chk("midreset lives before", int'(bus.lives), 2);
    chk("midreset dir before", int'(bus.dir_out), 3);
    rst = 1;
    step();
    chk_idle("midreset");
    step();
    chk_idle("midreset held");
    rst = 0;
    step();
    chk_idle("midreset released");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
